// File: rtl/ahbl_apb3_bridge_if.sv
// Signal bundle between the AHB-Lite fabric, the AHB-to-APB3 bridge and its APB3 peripherals.
// The slave modport is the bridge's view; the master modport is the surrounding system's view.
interface ahbl_apb3_bridge_if #(
  parameter int PADDR_WIDTH = 12
);
  logic                   HSEL;
  logic [31:0]            HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [2:0]             HSIZE;
  logic [31:0]            HWDATA;
  logic                   HREADY;
  logic                   HREADYOUT;
  logic                   HRESP;
  logic [31:0]            HRDATA;
  logic [PADDR_WIDTH-1:0] PADDR;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [31:0]            PWDATA;
  logic [31:0]            PRDATA;
  logic                   PREADY;
  logic                   PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge: one outstanding transfer, APB wait states,
// PSLVERR mapped to the two-cycle AHB ERROR response, and an optional PREADY timeout.
module ahbl_apb3_bridge #(
  parameter int PADDR_WIDTH    = 12,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic               HCLK,
  input logic               HRESETN,
  ahbl_apb3_bridge_if.slave bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [31:0]            hrdata_q, hrdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic acc;
  logic timeout_hit;
  logic psel, penable, hreadyout, hresp;

  // HSIZE, HTRANS[0] and the upper address bits carry no meaning for a word-only APB bridge.
  logic unused_bits;
  assign unused_bits = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[31:PADDR_WIDTH]};

  assign acc         = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q  <= ST_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (acc) begin
          state_d  = ST_SETUP;
          paddr_d  = bus.HADDR[PADDR_WIDTH-1:0];
          pwrite_d = bus.HWRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!pwrite_q) hrdata_d = bus.PRDATA;
          end
        end else begin
          // Saturating count of PREADY-low cycles; the last allowed one aborts the transfer.
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (timeout_hit) state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      ST_SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
      end
      ST_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = 1'b0;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
      default: ;
    endcase
  end

  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PWDATA    = bus.HWDATA;

endmodule

// File: doc/ahbl_apb3_bridge.md
Name: ahbl_apb3_bridge

Overview:
- AHB-Lite slave to APB3 master bridge. Sits directly downstream of the AHB-Lite bus-functional master (through the AHB decoder's HSEL) and converts each AHB-Lite transfer into one APB3 transfer for peripherals such as CoreGPIO.
- Single clock domain: HCLK drives both the AHB and APB sides, and there is no separate PCLK.
- Handles one outstanding transfer, APB wait states, PSLVERR, and an optional PREADY timeout.

Parameters:
- PADDR_WIDTH, 12, width of PADDR; taken from HADDR[PADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 0, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- HCLK  in  1  clock.
- HRESETN  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from the AHB decoder.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; only bit 1 (NONSEQ/SEQ) is used.
- HWRITE  in  1  write when 1.
- HSIZE  in  3  ignored; every transfer is a full 32-bit word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- HRDATA  out  32  read data.
- PADDR  out  PADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Clocking and reset:
  - One clock, HCLK.
  - Reset is synchronous and active-low on HRESETN, sampled at the HCLK rising edge, and overrides every other event including a transfer in progress.
  - An in-flight APB transfer is abandoned without completing.
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, HRDATA=0, HREADYOUT=1, HRESP=0, timeout counter=0.
- Accept condition: acc = HSEL & HREADY & HTRANS[1], evaluated only in IDLE, DONE and ERR2. On acc:
  - register PADDR <= HADDR[PADDR_WIDTH-1:0] and PWRITE <= HWRITE;
  - go to SETUP.
  - IDLE/BUSY transfers (HTRANS[1]=0) are ignored with an OKAY response.
- PWDATA = HWDATA, combinational. It is stable because the master holds HWDATA while HREADYOUT=0.
- State machine (registered outputs):
  - IDLE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Always goes to ACCESS; clear the counter.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. Counter increments each cycle PREADY=0.
    - PREADY=1 & PSLVERR=0 -> DONE, with HRDATA <= PRDATA on reads; HRDATA is unchanged on writes.
    - PREADY=1 & PSLVERR=1 -> ERR1.
    - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with PREADY=0 -> ERR1, with PSEL and PENABLE dropped.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. acc -> SETUP, else -> IDLE.
  - ERR1: PSEL=0, HREADYOUT=0, HRESP=1. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. acc -> SETUP, else -> IDLE. This is the second cycle of the two-cycle AHB error response; the master may cancel the next transfer with IDLE.
- Latency: transfer accepted at edge N gives SETUP at N+1, ACCESS at N+2, and with PREADY=1 at N+2, DONE at N+3 (HREADYOUT=1). Each PREADY-low cycle adds one cycle.
- Back-to-back transfers: an address phase accepted in DONE or ERR2 starts SETUP in the next cycle with no IDLE gap.
- HREADYOUT is never 0 in IDLE. PSEL is never 1 outside SETUP and ACCESS. PENABLE is never 1 outside ACCESS.
- PADDR and PWRITE are held constant from SETUP through ACCESS.
- The counter width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It saturates and does not wrap.

Test Plan:
- Write, zero wait: HADDR=0x0000_0004, HWRITE=1, HWDATA=0xA5A5_0001, PREADY tied 1 -> SETUP then ACCESS with PADDR=0x004, PWDATA=0xA5A5_0001; HREADYOUT low 2 cycles then high; HRESP=0.
- Read, 3 wait states: HADDR=0x08, PRDATA=0x1234_5678, PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles; HRDATA=0x1234_5678 while HREADYOUT=1; HREADYOUT low 5 cycles total.
- PSLVERR: write with PSLVERR=1 at PREADY -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 -> exactly 4 ACCESS cycles, then PSEL=0 and the two-cycle ERROR response; a following read with PREADY=1 completes OKAY.
- Back-to-back and reset: write 0x10 then read 0x14 pipelined -> second SETUP in the cycle after DONE. Repeat with HRESETN=0 for one cycle during ACCESS -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA=0, state IDLE.
